// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 16;

    // Bit of the microcode word that marks end-of-instruction.
    localparam int MC_END_BIT = 22;

    // Instruction word that parks the unit in HALTED.
    localparam logic [INSTR_W-1:0] DEF_HALT_OPCODE = 16'hF000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit handshake bundle: memory fetch handshake, execution-stage controls, status.
// Latency: n/a (wires only).
// Backpressure: fetch_req held until fetch_ack; exec_run held until mc_end.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int RETIRE_W = 16
) ();
    logic               run;
    logic [INSTR_W-1:0] bus;
    logic               fetch_ack;
    logic               mc_end;
    logic [INSTR_W-1:0] instruction;
    logic               fetch_req;
    logic               pc_out;
    logic               pc_inc;
    logic               exec_run;
    logic               halted;
    logic               fault;
    logic [RETIRE_W-1:0] retired;

    // Fetch unit side.
    modport master (
        input  run, bus, fetch_ack, mc_end,
        output instruction, fetch_req, pc_out, pc_inc, exec_run, halted, fault, retired
    );

    // Memory path / execution stage / control side.
    modport slave (
        output run, bus, fetch_ack, mc_end,
        input  instruction, fetch_req, pc_out, pc_inc, exec_run, halted, fault, retired
    );
endinterface

// File: rtl/instr_fetch_unit_fetch_timeout_counter.sv
// Loadable up-counter timing a pending fetch; flags the last allowed cycle.
// Latency: count updates one cycle after inc_i; term_o is a decode of the current count.
// Backpressure: none; clear has priority over load, load over increment.
module fetch_timeout_counter #(
    parameter int FETCH_TIMEOUT = 16,
    parameter int CNT_W         = $clog2(FETCH_TIMEOUT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, then load, then increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal when the last cycle before the fault has been reached.
    assign term_o = (cnt_q == CNT_W'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches 16-bit instruction words and holds them while the execution stage runs microcode.
// Latency: min 3-cycle instruction period (FETCH with immediate ack, DECODE, one EXEC cycle).
// Backpressure: fetch_req held until fetch_ack or timeout; EXEC held until mc_end.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                 FETCH_TIMEOUT = 16,
    parameter logic [INSTR_W-1:0] HALT_OPCODE   = DEF_HALT_OPCODE,
    parameter int                 RETIRE_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    instr_fetch_unit_if.master    ifc
);

    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                fault_q, fault_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                run_prev_q;

    logic                fetch_req_q;
    logic                pc_inc_q;
    logic                exec_run_q;
    logic                halted_q;

    logic                cnt_clr;
    logic                cnt_inc;
    logic                cnt_term;

    fetch_timeout_counter #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .load_i     (1'b0),
        .load_val_i ({CNT_W{1'b0}}),
        .term_o     (cnt_term)
    );

    // Next-state, instruction capture, fault and retire bookkeeping.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        fault_d   = fault_q;
        retired_d = retired_q;
        cnt_clr   = 1'b1;
        cnt_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ifc.run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Ack beats timeout when both land in the same cycle.
                if (ifc.fetch_ack) begin
                    instr_d = ifc.bus;
                    state_d = ST_DECODE;
                end else if (cnt_term) begin
                    fault_d = 1'b1;
                    state_d = ST_HALTED;
                end else begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                state_d = (instr_q == HALT_OPCODE) ? ST_HALTED : ST_EXEC;
            end
            ST_EXEC: begin
                if (ifc.mc_end) begin
                    retired_d = retired_q + RETIRE_W'(1);
                    state_d   = ifc.run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALTED: begin
                // Only a fresh run rising edge restarts; a held run does not.
                if (ifc.run && !run_prev_q) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and outputs; outputs are registered decodes of the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            fault_q     <= 1'b0;
            retired_q   <= '0;
            run_prev_q  <= 1'b0;
            fetch_req_q <= 1'b0;
            pc_inc_q    <= 1'b0;
            exec_run_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            fault_q     <= fault_d;
            retired_q   <= retired_d;
            run_prev_q  <= ifc.run;
            fetch_req_q <= (state_d == ST_FETCH);
            pc_inc_q    <= (state_d == ST_DECODE);
            exec_run_q  <= (state_d == ST_EXEC);
            halted_q    <= (state_d == ST_HALTED);
        end
    end

    assign ifc.instruction = instr_q;
    assign ifc.fetch_req   = fetch_req_q;
    assign ifc.pc_out      = fetch_req_q;
    assign ifc.pc_inc      = pc_inc_q;
    assign ifc.exec_run    = exec_run_q;
    assign ifc.halted      = halted_q;
    assign ifc.fault       = fault_q;
    assign ifc.retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of fetched words plus directed checks.
// Latency: n/a.
// Backpressure: bench models the memory path and execution stage.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [15:0] sb_q[$];
    logic [31:0] mcword;
    logic        exec_prev;

    instr_fetch_unit_if #(.RETIRE_W(16)) ifc ();

    instr_fetch_unit #(
        .FETCH_TIMEOUT (16),
        .HALT_OPCODE   (16'hF000),
        .RETIRE_W      (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ifc   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Wait for fetch_req, ack after lat cycles with word w; optionally expect it in EXEC.
    task automatic do_fetch(input logic [15:0] w, input int lat, input bit expect_exec);
        int k;
        k = 0;
        while (!ifc.fetch_req && k < 20) begin
            step();
            k++;
        end
        chk("fetch_req_seen", 32'(ifc.fetch_req), 32'd1);
        repeat (lat - 1) step();
        ifc.bus       = w;
        ifc.fetch_ack = 1'b1;
        if (expect_exec) sb_q.push_back(w);
        step();
        ifc.fetch_ack = 1'b0;
        ifc.bus       = 16'h0000;
    endtask

    // One-cycle end-of-instruction pulse from the microcode word.
    task automatic end_instr();
        mcword      = 32'd1 << MC_END_BIT;
        ifc.mc_end  = mcword[MC_END_BIT];
        step();
        mcword      = 32'd0;
        ifc.mc_end  = mcword[MC_END_BIT];
    endtask

    // Scoreboard: every entry into EXEC must present the next expected word.
    always @(negedge clock) begin
        if (!reset && ifc.exec_run && !exec_prev) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_exec", 32'(ifc.instruction), 32'hFFFF_FFFF);
            end else begin
                chk("sb_instr", 32'(ifc.instruction), 32'(sb_q.pop_front()));
            end
        end
        exec_prev = ifc.exec_run;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        exec_prev     = 1'b0;
        mcword        = 32'd0;
        reset         = 1'b1;
        ifc.run       = 1'b0;
        ifc.bus       = 16'h0000;
        ifc.fetch_ack = 1'b0;
        ifc.mc_end    = 1'b0;
        repeat (3) step();
        chk("rst_instr",    32'(ifc.instruction), 32'h0);
        chk("rst_fetch_req",32'(ifc.fetch_req),   32'd0);
        chk("rst_exec_run", 32'(ifc.exec_run),    32'd0);
        chk("rst_halted",   32'(ifc.halted),      32'd0);
        chk("rst_fault",    32'(ifc.fault),       32'd0);
        chk("rst_retired",  32'(ifc.retired),     32'd0);
        reset = 1'b0;
        step();
        chk("idle_no_req", 32'(ifc.fetch_req), 32'd0);

        // First instruction, ack two cycles after fetch_req.
        ifc.run = 1'b1;
        step();
        chk("fetch_req_rise", 32'(ifc.fetch_req), 32'd1);
        chk("pc_out_eq_req",  32'(ifc.pc_out),    32'd1);
        do_fetch(16'h1234, 2, 1'b1);
        chk("dec_pc_inc",    32'(ifc.pc_inc),      32'd1);
        chk("dec_instr",     32'(ifc.instruction), 32'h1234);
        chk("dec_fetch_req", 32'(ifc.fetch_req),   32'd0);
        chk("dec_exec_run",  32'(ifc.exec_run),    32'd0);
        step();
        chk("exec_run",      32'(ifc.exec_run),    32'd1);
        chk("exec_pc_inc",   32'(ifc.pc_inc),      32'd0);
        chk("exec_req",      32'(ifc.fetch_req),   32'd0);
        repeat (4) step();
        chk("exec_hold",     32'(ifc.instruction), 32'h1234);
        chk("exec_still",    32'(ifc.exec_run),    32'd1);
        end_instr();
        chk("retired_1",     32'(ifc.retired),     32'd1);
        chk("refetch_1",     32'(ifc.fetch_req),   32'd1);

        // Second instruction at minimum period.
        do_fetch(16'h2A08, 1, 1'b1);
        step();
        end_instr();
        chk("retired_2",     32'(ifc.retired),     32'd2);
        chk("refetch_2",     32'(ifc.fetch_req),   32'd1);
        chk("exec_off_2",    32'(ifc.exec_run),    32'd0);

        // Timeout: fetch_req rose at the last edge, no ack ever.
        repeat (15) step();
        chk("to_not_yet_halt", 32'(ifc.halted),    32'd0);
        chk("to_still_req",    32'(ifc.fetch_req), 32'd1);
        step();
        chk("to_halted",       32'(ifc.halted),    32'd1);
        chk("to_fault",        32'(ifc.fault),     32'd1);
        chk("to_req_off",      32'(ifc.fetch_req), 32'd0);
        repeat (3) step();
        chk("held_run_no_restart", 32'(ifc.halted), 32'd1);
        ifc.run = 1'b0;
        step();
        ifc.run = 1'b1;
        step();
        chk("restart_req",    32'(ifc.fetch_req), 32'd1);
        chk("restart_halted", 32'(ifc.halted),    32'd0);
        chk("fault_sticky",   32'(ifc.fault),     32'd1);

        // HALT opcode: one pc_inc, no EXEC, no retire.
        do_fetch(16'hF000, 1, 1'b0);
        chk("halt_pc_inc",   32'(ifc.pc_inc),   32'd1);
        step();
        chk("halt_halted",   32'(ifc.halted),   32'd1);
        chk("halt_pc_inc_0", 32'(ifc.pc_inc),   32'd0);
        chk("halt_retired",  32'(ifc.retired),  32'd2);
        repeat (2) step();
        chk("halt_no_exec",  32'(ifc.exec_run), 32'd0);

        // Run dropped during EXEC: finish instruction, then IDLE.
        ifc.run = 1'b0;
        step();
        ifc.run = 1'b1;
        step();
        do_fetch(16'h0055, 1, 1'b1);
        step();
        ifc.run = 1'b0;
        repeat (2) step();
        chk("drop_still_exec", 32'(ifc.exec_run), 32'd1);
        end_instr();
        chk("drop_retired",  32'(ifc.retired),   32'd3);
        chk("drop_no_req",   32'(ifc.fetch_req), 32'd0);
        chk("drop_no_exec",  32'(ifc.exec_run),  32'd0);
        // Ack and mc_end in IDLE are ignored.
        ifc.bus       = 16'hBEEF;
        ifc.fetch_ack = 1'b1;
        mcword        = 32'd1 << MC_END_BIT;
        ifc.mc_end    = mcword[MC_END_BIT];
        step();
        ifc.fetch_ack = 1'b0;
        ifc.bus       = 16'h0000;
        mcword        = 32'd0;
        ifc.mc_end    = mcword[MC_END_BIT];
        chk("idle_ignore_bus", 32'(ifc.instruction), 32'h0055);
        chk("idle_ignore_end", 32'(ifc.retired),     32'd3);
        chk("idle_req_low",    32'(ifc.fetch_req),   32'd0);
        ifc.run = 1'b1;
        step();
        chk("resume_req",      32'(ifc.fetch_req),   32'd1);

        // Asynchronous reset in the middle of EXEC.
        do_fetch(16'h0777, 3, 1'b1);
        step();
        step();
        chk("pre_rst_exec",  32'(ifc.exec_run),    32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_exec_run", 32'(ifc.exec_run),    32'd0);
        chk("arst_req",      32'(ifc.fetch_req),   32'd0);
        chk("arst_retired",  32'(ifc.retired),     32'd0);
        chk("arst_instr",    32'(ifc.instruction), 32'h0);
        repeat (2) step();
        chk("sb_drained",    32'(sb_q.size()),     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
